// File: rtl/alu_share_if.sv
// Bundle of requester, ALU and arbiter-output signals for the shared-ALU arbiter.
// The arbiter connects through the slave modport; requesters and the ALU model use master.
interface alu_share_if #(
  parameter int W = 32
);
  logic         req_a;
  logic [2:0]   op_a;
  logic [W-1:0] a_a;
  logic [W-1:0] b_a;
  logic         req_b;
  logic [2:0]   op_b;
  logic [W-1:0] a_b;
  logic [W-1:0] b_b;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         gnt_a;
  logic         gnt_b;
  logic         done_a;
  logic         done_b;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  modport slave (
    input  req_a, op_a, a_a, b_a, req_b, op_b, a_b, b_b, alu_result, alu_zero,
    output alu_op, alu_a, alu_b, gnt_a, gnt_b, done_a, done_b, result, zero, busy
  );

  modport master (
    output req_a, op_a, a_a, b_a, req_b, op_b, a_b, b_b, alu_result, alu_zero,
    input  alu_op, alu_a, alu_b, gnt_a, gnt_b, done_a, done_b, result, zero, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between the fetch path (A) and execute path (B).
// Each operation runs IDLE -> EXEC -> DONE; the winner gets result/zero with a one-cycle done pulse.
module alu_share_arbiter #(
  parameter int W = 32
) (
  input logic        clk,
  input logic        rst,
  alu_share_if.slave arb_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         last_q, last_d;       // 1: B won most recently
  logic [2:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] res_q, res_d;
  logic         zero_q, zero_d;
  logic         gnt_a_q, gnt_a_d;
  logic         gnt_b_q, gnt_b_d;
  logic         done_a_q, done_a_d;
  logic         done_b_q, done_b_d;
  logic         win_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    zero_d   = zero_q;
    gnt_a_d  = gnt_a_q;
    gnt_b_d  = gnt_b_q;
    done_a_d = done_a_q;
    done_b_d = done_b_q;
    // B wins when it is alone, or when both ask and A went last
    win_b    = arb_if.req_b && (!arb_if.req_a || !last_q);

    unique case (state_q)
      IDLE: begin
        if (arb_if.req_a || arb_if.req_b) begin
          op_d    = win_b ? arb_if.op_b : arb_if.op_a;
          a_d     = win_b ? arb_if.a_b  : arb_if.a_a;
          b_d     = win_b ? arb_if.b_b  : arb_if.b_a;
          last_d  = win_b;
          gnt_a_d = !win_b;
          gnt_b_d = win_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d    = arb_if.alu_result;
        zero_d   = arb_if.alu_zero;
        done_a_d = gnt_a_q;
        done_b_d = gnt_b_q;
        state_d  = DONE;
      end
      DONE: begin
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign arb_if.alu_op = op_q;
  assign arb_if.alu_a  = a_q;
  assign arb_if.alu_b  = b_q;
  assign arb_if.gnt_a  = gnt_a_q;
  assign arb_if.gnt_b  = gnt_b_q;
  assign arb_if.done_a = done_a_q;
  assign arb_if.done_b = done_b_q;
  assign arb_if.result = res_q;
  assign arb_if.zero   = zero_q;
  assign arb_if.busy   = (state_q != IDLE);

endmodule
